mem_stage: RTL and testbench

Memory-access stage of the rv32i pipeline, sitting between the execute stage and `wb_stage`. It issues loads and stores to the data memory over a request/ready handshake, formats load data, and registers the `opcode`, `c`, `d` and `pc_from_mem` values that `wb_stage` consumes. It stalls upstream while a memory transaction is outstanding and retires exactly one instruction per accepted input.

---
 rtl/mem_stage.sv | 259 +++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the rv32i pipeline (execute -> mem -> wb_stage).
//
// Issues loads/stores to data memory over a req/ready handshake, formats load
// data, and registers opcode/c/d/pc_from_mem for wb_stage. Exactly one
// retirement (wb_valid pulse) per accepted instruction.
//
// Parameters:
//   TIMEOUT_CYCLES : WAIT cycles without dmem_ready before abort with bus_err.
// Optional feature:
//   MEM_MISALIGN_CHECK_EN : when defined, misaligned halfword/word accesses skip
//                           the bus and retire in one cycle with misaligned=1.
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   in_valid, opcode_in, funct3_in : upstream instruction
//   c_in, b_in, pc_in              : address/ALU result, store data, pc
//   stall                          : hold upstream
//   dmem_req/we/addr/wdata/be      : memory request (registered)
//   dmem_rdata, dmem_ready         : memory response
//   opcode, c, d, pc_from_mem      : to wb_stage
//   wb_valid, misaligned, bus_err  : one-cycle retirement pulses
module mem_stage #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [6:0]  opcode_in,
   input  logic [2:0]  funct3_in,
   input  logic [31:0] c_in,
   input  logic [31:0] b_in,
   input  logic [31:0] pc_in,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ready,
   output logic [6:0]  opcode,
   output logic [31:0] c,
   output logic [31:0] d,
   output logic [31:0] pc_from_mem,
   output logic        wb_valid,
   output logic        misaligned,
   output logic        bus_err
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam int         CW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt;

   // instruction latched for the duration of the bus access
   logic [6:0]      r_op;
   logic [2:0]      r_f3;
   logic [31:0]     r_a;
   logic [31:0]     r_pc;

   logic            r_dmem_req, r_dmem_we;
   logic [31:0]     r_dmem_addr, r_dmem_wdata;
   logic [3:0]      r_dmem_be;
   logic [6:0]      r_opcode;
   logic [31:0]     r_c, r_d, r_pc_out;
   logic            r_wb_valid, r_mis, r_err;

   logic            w_is_load, w_is_store, w_is_mem, w_mis_in;
   logic            w_stall, w_done, w_timeout;
   logic [3:0]      w_be;
   logic [31:0]     w_wdata;
   logic [31:0]     w_ld;
   logic [7:0]      w_byte;
   logic [15:0]     w_half;

   assign w_is_load  = (opcode_in == OP_LOAD);
   assign w_is_store = (opcode_in == OP_STORE);
   assign w_is_mem   = w_is_load | w_is_store;

`ifdef MEM_MISALIGN_CHECK_EN
   // Unlisted funct3 values behave as word accesses, so they need full alignment.
   always_comb begin
      w_mis_in = 1'b0;
      if (w_is_load) begin
         case (funct3_in)
            3'b000, 3'b100: w_mis_in = 1'b0;
            3'b001, 3'b101: w_mis_in = c_in[0];
            default:        w_mis_in = |c_in[1:0];
         endcase
      end else if (w_is_store) begin
         case (funct3_in)
            3'b000:  w_mis_in = 1'b0;
            3'b001:  w_mis_in = c_in[0];
            default: w_mis_in = |c_in[1:0];
         endcase
      end
   end
`else
   assign w_mis_in = 1'b0;
`endif

   // Store lane placement; loads always read the full word.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = 32'h0;
      if (w_is_store) begin
         case (funct3_in)
            3'b000: begin
               w_be    = 4'b0001 << c_in[1:0];
               w_wdata = {4{b_in[7:0]}};
            end
            3'b001: begin
               w_be    = 4'b0011 << {c_in[1], 1'b0};
               w_wdata = {2{b_in[15:0]}};
            end
            default: begin
               w_be    = 4'b1111;
               w_wdata = b_in;
            end
         endcase
      end
   end

   // Load formatting from the latched address/funct3.
   assign w_byte = dmem_rdata[{r_a[1:0], 3'b000} +: 8];
   assign w_half = r_a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

   always_comb begin
      case (r_f3)
         3'b000:  w_ld = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_ld = {24'h0, w_byte};
         3'b001:  w_ld = {{16{w_half[15]}}, w_half};
         3'b101:  w_ld = {16'h0, w_half};
         default: w_ld = dmem_rdata;
      endcase
   end

   // A late dmem_ready in the final counted cycle still wins over the abort.
   assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1)) & ~dmem_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid && w_is_mem && !w_mis_in) begin
               w_stall     = 1'b1;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            w_stall = 1'b1;
            if (dmem_ready || w_timeout) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Gate with reset so stall is 0 while reset is asserted, even with in_valid high.
   assign stall = rst_n & w_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_op         <= '0;
         r_f3         <= '0;
         r_a          <= '0;
         r_pc         <= '0;
         r_dmem_req   <= 1'b0;
         r_dmem_we    <= 1'b0;
         r_dmem_addr  <= '0;
         r_dmem_wdata <= '0;
         r_dmem_be    <= '0;
         r_opcode     <= '0;
         r_c          <= '0;
         r_d          <= '0;
         r_pc_out     <= '0;
         r_wb_valid   <= 1'b0;
         r_mis        <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         // retirement pulses default low; c/d/pc hold their last value
         r_opcode   <= '0;
         r_wb_valid <= 1'b0;
         r_mis      <= 1'b0;
         r_err      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  if (w_is_mem && !w_mis_in) begin
                     r_op         <= opcode_in;
                     r_f3         <= funct3_in;
                     r_a          <= c_in;
                     r_pc         <= pc_in;
                     r_cnt        <= '0;
                     r_dmem_req   <= 1'b1;
                     r_dmem_we    <= w_is_store;
                     r_dmem_addr  <= {c_in[31:2], 2'b00};
                     r_dmem_wdata <= w_wdata;
                     r_dmem_be    <= w_be;
                  end else begin
                     // non-memory op, or a suppressed misaligned access
                     r_opcode   <= opcode_in;
                     r_c        <= c_in;
                     r_d        <= '0;
                     r_pc_out   <= pc_in;
                     r_wb_valid <= 1'b1;
                     r_mis      <= w_mis_in;
                  end
               end
            end
            S_WAIT: begin
               if (w_done) begin
                  r_opcode     <= r_op;
                  r_c          <= r_a;
                  r_pc_out     <= r_pc;
                  r_d          <= (dmem_ready && r_op == OP_LOAD) ? w_ld : 32'h0;
                  r_wb_valid   <= 1'b1;
                  r_err        <= ~dmem_ready;
                  r_dmem_req   <= 1'b0;
                  r_dmem_we    <= 1'b0;
                  r_dmem_addr  <= '0;
                  r_dmem_wdata <= '0;
                  r_dmem_be    <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign dmem_req    = r_dmem_req;
   assign dmem_we     = r_dmem_we;
   assign dmem_addr   = r_dmem_addr;
   assign dmem_wdata  = r_dmem_wdata;
   assign dmem_be     = r_dmem_be;
   assign opcode      = r_opcode;
   assign c           = r_c;
   assign d           = r_d;
   assign pc_from_mem = r_pc_out;
   assign wb_valid    = r_wb_valid;
   assign misaligned  = r_mis;
   assign bus_err     = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboarded bench for mem_stage: stimulus pushes expected retirements,
// a monitor pops and compares on every wb_valid pulse.
module tb_mem_stage;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [6:0]  opcode_in = '0;
   logic [2:0]  funct3_in = '0;
   logic [31:0] c_in = '0, b_in = '0, pc_in = '0;
   logic        stall, dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_rdata = '0;
   logic        dmem_ready = 1'b0;
   logic [6:0]  opcode;
   logic [31:0] c, d, pc_from_mem;
   logic        wb_valid, misaligned, bus_err;

   mem_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opcode_in(opcode_in),
      .funct3_in(funct3_in), .c_in(c_in), .b_in(b_in), .pc_in(pc_in),
      .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
      .dmem_ready(dmem_ready), .opcode(opcode), .c(c), .d(d),
      .pc_from_mem(pc_from_mem), .wb_valid(wb_valid), .misaligned(misaligned),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [6:0]  op;
      logic [31:0] c;
      logic [31:0] d;
      logic [31:0] pc;
      logic        mis;
      logic        err;
   } exp_t;

   exp_t q[$];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && wb_valid === 1'b1) begin
            n_total++;
            if (q.size() == 0) begin
               $display("FAIL retire: unexpected wb_valid opcode=%h c=%h d=%h", opcode, c, d);
            end else begin
               e = q.pop_front();
               if ({opcode, c, d, pc_from_mem, misaligned, bus_err} === e) n_pass++;
               else $display("FAIL retire pc=%h: got op=%h c=%h d=%h pc=%h mis=%b err=%b expected op=%h c=%h d=%h pc=%h mis=%b err=%b",
                             e.pc, opcode, c, d, pc_from_mem, misaligned, bus_err,
                             e.op, e.c, e.d, e.pc, e.mis, e.err);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
      in_valid = 1'b1; opcode_in = op; funct3_in = f3; c_in = a; b_in = b; pc_in = pc;
   endtask

   task automatic exp_push(input logic [6:0] op, input logic [31:0] a, input logic [31:0] dd,
                           input logic [31:0] pc, input logic mis, input logic err);
      exp_t e;
      e = '{op: op, c: a, d: dd, pc: pc, mis: mis, err: err};
      q.push_back(e);
   endtask

   // Full bus access: waits+1 WAIT cycles, ready asserted on the last one if rdy_end.
   task automatic mem_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc, input logic [31:0] rdata,
                         input int waits, input logic rdy_end, input logic [31:0] e_addr,
                         input logic [3:0] e_be, input logic [31:0] e_wdata, input string tag);
      drive(op, f3, a, b, pc);
      mid();
      chk({tag, " stall@accept"}, {31'h0, stall}, 32'h1);
      step();
      in_valid = 1'b0;
      for (int i = 0; i <= waits; i++) begin
         dmem_ready = (i == waits) && rdy_end;
         dmem_rdata = rdata;
         mid();
         chk({tag, " req"},   {31'h0, dmem_req}, 32'h1);
         chk({tag, " stall"}, {31'h0, stall}, 32'h1);
         chk({tag, " we"},    {31'h0, dmem_we}, {31'h0, op == OP_STORE});
         chk({tag, " addr"},  dmem_addr, e_addr);
         chk({tag, " be"},    {28'h0, dmem_be}, {28'h0, e_be});
         chk({tag, " wdata"}, dmem_wdata, e_wdata);
         step();
      end
      dmem_ready = 1'b0;
      mid();
      chk({tag, " req@done"},   {31'h0, dmem_req}, 32'h0);
      chk({tag, " stall@done"}, {31'h0, stall}, 32'h0);
   endtask

   initial begin
      // reset state
      mid();
      chk("reset outs", {25'h0, opcode, dmem_be, stall, dmem_req, dmem_we, wb_valid, misaligned, bus_err},
          32'h0);
      chk("reset addr", dmem_addr | dmem_wdata | c | d | pc_from_mem, 32'h0);
      step();
      rst_n = 1'b1;
      step();

      // non-memory op
      exp_push(OP_LUI, 32'h1, 32'h0, 32'h4, 1'b0, 1'b0);
      drive(OP_LUI, 3'b000, 32'h1, 32'h0, 32'h4);
      mid();
      chk("nonmem stall", {31'h0, stall}, 32'h0);
      step();
      in_valid = 1'b0;
      mid();
      chk("nonmem req", {31'h0, dmem_req}, 32'h0);
      step();

      // LB, zero wait states, sign-extend byte 3
      exp_push(OP_LOAD, 32'h103, 32'hFFFF_FF80, 32'h8, 1'b0, 1'b0);
      mem_op(OP_LOAD, 3'b000, 32'h103, 32'h0, 32'h8, 32'h80FF_0000, 0, 1'b1,
             32'h100, 4'b1111, 32'h0, "LB");
      step();

      // SH, 3 wait states
      exp_push(OP_STORE, 32'h202, 32'h0, 32'hC, 1'b0, 1'b0);
      mem_op(OP_STORE, 3'b001, 32'h202, 32'h1234_ABCD, 32'hC, 32'h0, 3, 1'b1,
             32'h200, 4'b1100, 32'hABCD_ABCD, "SH");
      step();

      // SB lane 1
      exp_push(OP_STORE, 32'h101, 32'h0, 32'h10, 1'b0, 1'b0);
      mem_op(OP_STORE, 3'b000, 32'h101, 32'h0000_0055, 32'h10, 32'h0, 0, 1'b1,
             32'h100, 4'b0010, 32'h5555_5555, "SB");
      step();

      // LHU timeout after 4 WAIT cycles
      exp_push(OP_LOAD, 32'h10, 32'h0, 32'h14, 1'b0, 1'b1);
      mem_op(OP_LOAD, 3'b101, 32'h10, 32'h0, 32'h14, 32'hFFFF_FFFF, 3, 1'b0,
             32'h10, 4'b1111, 32'h0, "LHU-to");
      step();

      // ready in the final timeout cycle completes normally
      exp_push(OP_LOAD, 32'h12, 32'h0000_8001, 32'h18, 1'b0, 1'b0);
      mem_op(OP_LOAD, 3'b101, 32'h12, 32'h0, 32'h18, 32'h8001_0000, 3, 1'b1,
             32'h10, 4'b1111, 32'h0, "LHU-edge");
      step();

      // LH sign-extended upper half, then LW
      exp_push(OP_LOAD, 32'h22, 32'hFFFF_8001, 32'h1C, 1'b0, 1'b0);
      mem_op(OP_LOAD, 3'b001, 32'h22, 32'h0, 32'h1C, 32'h8001_0000, 1, 1'b1,
             32'h20, 4'b1111, 32'h0, "LH");
      exp_push(OP_LOAD, 32'h40, 32'hCAFE_F00D, 32'h20, 1'b0, 1'b0);
      mem_op(OP_LOAD, 3'b010, 32'h40, 32'h0, 32'h20, 32'hCAFE_F00D, 0, 1'b1,
             32'h40, 4'b1111, 32'h0, "LW");
      step();

      // misaligned LW / SW
`ifdef MEM_MISALIGN_CHECK_EN
      exp_push(OP_LOAD, 32'h1, 32'h0, 32'h24, 1'b1, 1'b0);
      drive(OP_LOAD, 3'b010, 32'h1, 32'h0, 32'h24);
      mid();
      chk("misLW stall", {31'h0, stall}, 32'h0);
      step();
      exp_push(OP_STORE, 32'h2, 32'h0, 32'h28, 1'b1, 1'b0);
      drive(OP_STORE, 3'b010, 32'h2, 32'h1122_3344, 32'h28);
      mid();
      chk("misLW req", {31'h0, dmem_req}, 32'h0);
      chk("misSW stall", {31'h0, stall}, 32'h0);
      step();
      in_valid = 1'b0;
      mid();
      chk("misSW req", {31'h0, dmem_req}, 32'h0);
      step();
`else
      exp_push(OP_LOAD, 32'h1, 32'hDEAD_BEEF, 32'h24, 1'b0, 1'b0);
      mem_op(OP_LOAD, 3'b010, 32'h1, 32'h0, 32'h24, 32'hDEAD_BEEF, 0, 1'b1,
             32'h0, 4'b1111, 32'h0, "misLW");
      step();
      exp_push(OP_STORE, 32'h2, 32'h0, 32'h28, 1'b0, 1'b0);
      mem_op(OP_STORE, 3'b010, 32'h2, 32'h1122_3344, 32'h28, 32'h0, 0, 1'b1,
             32'h0, 4'b1111, 32'h1122_3344, "misSW");
      step();
`endif

      // reset while in WAIT: abandoned, nothing retires
      drive(OP_LOAD, 3'b010, 32'h80, 32'h0, 32'h2C);
      step();
      in_valid = 1'b0;
      mid();
      chk("rstwait req", {31'h0, dmem_req}, 32'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("rstwait outs", {25'h0, opcode, dmem_be, stall, dmem_req, dmem_we, wb_valid, misaligned, bus_err},
          32'h0);
      chk("rstwait addr", dmem_addr, 32'h0);
      step();
      rst_n = 1'b1;
      step();
      exp_push(OP_LOAD, 32'h3, 32'h0000_0080, 32'h30, 1'b0, 1'b0);
      mem_op(OP_LOAD, 3'b100, 32'h3, 32'h0, 32'h30, 32'h8000_0000, 0, 1'b1,
             32'h0, 4'b1111, 32'h0, "LBU-post");
      step();
      step();

      chk("scoreboard drained", q.size(), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
